// File: rtl/inst_queue.sv
// Instruction buffer between fetch and decode: a circular FIFO whose head drives the decoder
// directly. A backend flush discards every entry, including any push in the same cycle.
module inst_queue #(
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_pc_i,
  input  logic [31:0]     in_inst_i,
  input  logic            in_pred_taken_i,
  input  logic [31:0]     in_pred_target_i,
  input  logic            in_fetch_excp_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [31:0]     out_pc_o,
  output logic [31:0]     out_inst_o,
  output logic            out_pred_taken_o,
  output logic [31:0]     out_pred_target_o,
  output logic            out_fetch_excp_o,
  output logic [PtrW:0]   count_o
);

  localparam logic [PtrW:0]   DepthCnt = (PtrW + 1)'(Depth);
  localparam logic [PtrW-1:0] PtrOne   = {{(PtrW - 1){1'b0}}, 1'b1};
  localparam logic [PtrW:0]   CntOne   = {{PtrW{1'b0}}, 1'b1};

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;

  // Payload storage carries no reset; validity is tracked solely by count_q.
  logic [31:0] pc_mem     [Depth];
  logic [31:0] inst_mem   [Depth];
  logic [31:0] target_mem [Depth];
  logic        taken_mem  [Depth];
  logic        excp_mem   [Depth];

  logic push, pop;

  assign in_ready_o  = (count_q != DepthCnt);
  assign out_valid_o = (count_q != '0);
  assign count_o     = count_q;

  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop  = out_valid_o & out_ready_i & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr_q]     <= in_pc_i;
      inst_mem[wr_ptr_q]   <= in_inst_i;
      target_mem[wr_ptr_q] <= in_pred_target_i;
      taken_mem[wr_ptr_q]  <= in_pred_taken_i;
      excp_mem[wr_ptr_q]   <= in_fetch_excp_i;
    end
  end

  always_comb begin
    out_pc_o          = '0;
    out_inst_o        = '0;
    out_pred_target_o = '0;
    out_pred_taken_o  = 1'b0;
    out_fetch_excp_o  = 1'b0;
    if (out_valid_o) begin
      out_pc_o          = pc_mem[rd_ptr_q];
      out_inst_o        = inst_mem[rd_ptr_q];
      out_pred_target_o = target_mem[rd_ptr_q];
      out_pred_taken_o  = taken_mem[rd_ptr_q];
      out_fetch_excp_o  = excp_mem[rd_ptr_q];
    end
  end

`ifndef SYNTHESIS
  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= DepthCnt);
  a_valid_count: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                  out_valid_o == (count_q != '0));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   !(push && count_q == DepthCnt));
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: the driver queues expected head entries, a negedge monitor
// pops and compares them whenever the DUT hands an entry to the decoder.
module tb_inst_queue;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        taken;
    logic [31:0] target;
    logic        excp;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_inst, in_target;
  logic        in_taken, in_excp;
  logic [31:0] out_pc, out_inst, out_target;
  logic        out_taken, out_excp;
  logic [3:0]  count;

  int     checks = 0;
  int     errors = 0;
  entry_t exp_q[$];

  inst_queue #(.Depth(8)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .flush_i           (flush),
    .in_valid_i        (in_valid),
    .in_ready_o        (in_ready),
    .in_pc_i           (in_pc),
    .in_inst_i         (in_inst),
    .in_pred_taken_i   (in_taken),
    .in_pred_target_i  (in_target),
    .in_fetch_excp_i   (in_excp),
    .out_valid_o       (out_valid),
    .out_ready_i       (out_ready),
    .out_pc_o          (out_pc),
    .out_inst_o        (out_inst),
    .out_pred_taken_o  (out_taken),
    .out_pred_target_o (out_target),
    .out_fetch_excp_o  (out_excp),
    .count_o           (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: mid-cycle, a handshake that will complete at the next edge must match the model.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 32'd1, 32'd0);
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        chk("head_pc", out_pc, e.pc);
        chk("head_inst", out_inst, e.inst);
        chk("head_taken", {31'd0, out_taken}, {31'd0, e.taken});
        chk("head_target", out_target, e.target);
        chk("head_excp", {31'd0, out_excp}, {31'd0, e.excp});
      end
    end
  end

  // One cycle of stimulus; checks occupancy against the model before applying it.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                     input logic tk, input logic [31:0] tgt, input logic ex,
                     input logic rdy, input logic fl);
    entry_t e;
    chk("count", {28'd0, count}, exp_q.size());
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < 8});
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    in_taken  = tk;
    in_target = tgt;
    in_excp   = ex;
    out_ready = rdy;
    flush     = fl;
    if (fl) begin
      exp_q.delete();
    end else if (v && exp_q.size() < 8) begin
      e = '{pc: pc, inst: inst, taken: tk, target: tgt, excp: ex};
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic rdy);
    cyc(1'b1, pc, pc ^ 32'h0280_0000, 1'b0, 32'd0, 1'b0, rdy, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0; in_taken = 1'b0; in_target = '0; in_excp = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_count", {28'd0, count}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // 1: single push then pop; out_ready on an empty queue is ignored
    cyc(1'b1, 32'h1c00_0000, 32'h0280_0421, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("t1_count", {28'd0, count}, 32'd1);
    chk("t1_pc", out_pc, 32'h1c00_0000);
    chk("t1_inst", out_inst, 32'h0280_0421);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    // 2: fill to full, attempt a 9th push, then drain in order
    for (int i = 0; i < 8; i++) push(32'h1c00_0000 + 32'(4 * i), 1'b0);
    chk("t2_full_count", {28'd0, count}, 32'd8);
    push(32'hdead_0000, 1'b0);
    push(32'hdead_0004, 1'b1);
    for (int i = 0; i < 8; i++) idle(1'b1);
    idle(1'b0);

    // 3: steady stream, count stays at 1 while pointers wrap
    for (int i = 0; i < 20; i++) push(32'h1c00_1000 + 32'(4 * i), 1'b1);
    idle(1'b1);
    idle(1'b0);

    // 4: flush with push and pop both active at count=5
    for (int i = 0; i < 5; i++) push(32'h1c00_2000 + 32'(4 * i), 1'b0);
    cyc(1'b1, 32'hbad0_0000, 32'h0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    chk("t4_count", {28'd0, count}, 32'd0);
    chk("t4_valid", {31'd0, out_valid}, 32'd0);
    cyc(1'b1, 32'hbad0_0004, 32'h0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    idle(1'b1);

    // 5: prediction and exception fields carried through
    cyc(1'b1, 32'h1c00_3000, 32'h1234_5678, 1'b1, 32'h1c00_0100, 1'b1, 1'b0, 1'b0);
    chk("t5_taken", {31'd0, out_taken}, 32'd1);
    chk("t5_target", out_target, 32'h1c00_0100);
    chk("t5_excp", {31'd0, out_excp}, 32'd1);
    idle(1'b1);
    idle(1'b0);

    // 6: asynchronous reset while holding three entries
    for (int i = 0; i < 3; i++) push(32'h1c00_4000 + 32'(4 * i), 1'b0);
    in_valid = 1'b0;
    chk("t6_pre_count", {28'd0, count}, 32'd3);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_async_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_async_ready", {31'd0, in_ready}, 32'd1);
    chk("t6_async_count", {28'd0, count}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1'b1);
    push(32'h1c00_5000, 1'b0);
    idle(1'b1);
    idle(1'b0);
    chk("final_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
